// File: rtl/int_convert_pipe_if.sv
// int_convert_pipe_if: stream bundle for the integer width converter.
//
// Handshake: a beat moves on a rising clock edge where valid and ready are
// both 1. A producer keeps valid and its data steady until that edge. A
// consumer may raise or drop ready in any cycle.
//
// Signals:
//   in_valid_i / in_ready_o / inval_i / mode_i : input stream
//   out_valid_o / out_ready_i / output__ / ovf_o : output stream
//   ovf_count_o / clr_count_i : overflow counter and its clear
//
// Modports: master = producer/consumer side, slave = converter side.
interface int_convert_pipe_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [IN_W-1:0]  inval_i;
  logic [1:0]       mode_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] output__;
  logic             ovf_o;
  logic [CNT_W-1:0] ovf_count_o;
  logic             clr_count_i;

  modport master (
    output in_valid_i, inval_i, mode_i, out_ready_i, clr_count_i,
    input  in_ready_o, out_valid_o, output__, ovf_o, ovf_count_o
  );

  modport slave (
    input  in_valid_i, inval_i, mode_i, out_ready_i, clr_count_i,
    output in_ready_o, out_valid_o, output__, ovf_o, ovf_count_o
  );
endinterface

// File: rtl/int_convert_pipe.sv
// int_convert_pipe: two-stage registered integer width converter.
//
// Each item's mode picks how an IN_W-bit value becomes OUT_W bits:
//   00 unsigned wrap, 01 signed wrap, 10 signed saturate, 11 unsigned saturate.
// ovf marks an item whose value does not fit in the output. A saturating
// counter tallies the overflowed items that are delivered.
//
// Ports:
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset
//   bus   : int_convert_pipe_if.slave (stream in/out, counter, clear)
//
// S1 holds {inval, mode}. S2 holds {output__, ovf}. The conversion logic
// sits between S1 and S2.
module int_convert_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  int_convert_pipe_if.slave bus
);

  logic             s1_valid;
  logic [IN_W-1:0]  s1_data;
  logic [1:0]       s1_mode;
  logic             s2_valid;
  logic [OUT_W-1:0] s2_data;
  logic             s2_ovf;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_free;
  logic             accept;
  logic             deliver;
  logic             advance;
  logic [OUT_W-1:0] conv;
  logic             conv_ovf;

  // in_ready_o depends combinationally on out_ready_i. A full pipe can
  // still take an item in the same cycle that it delivers one.
  assign s2_free        = !s2_valid || bus.out_ready_i;
  assign bus.in_ready_o = !s1_valid || s2_free;
  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign deliver        = s2_valid && bus.out_ready_i;
  assign advance        = s1_valid && s2_free;

  assign bus.out_valid_o = s2_valid;
  assign bus.output__    = s2_data;
  assign bus.ovf_o       = s2_ovf;
  assign bus.ovf_count_o = cnt_q;

  generate
    if (OUT_W >= IN_W) begin : g_widen
      // Widening never overflows. Modes 01 and 10 are signed, so they
      // sign-extend. Modes 00 and 11 zero-extend.
      always_comb begin
        conv     = (s1_mode[0] ^ s1_mode[1]) ? OUT_W'($signed(s1_data))
                                             : OUT_W'(s1_data);
        conv_ovf = 1'b0;
      end
    end else begin : g_narrow
      localparam int D = IN_W - OUT_W;
      logic [OUT_W-1:0] low;
      logic [D-1:0]     disc;
      logic [D:0]       top;
      logic             u_ovf;
      logic             s_ovf;
      logic             neg;

      assign low  = s1_data[OUT_W-1:0];
      assign disc = s1_data[IN_W-1:OUT_W];
      // A signed value fits only if the discarded bits all copy the new
      // sign bit. That means the top D+1 bits are all equal.
      assign top   = s1_data[IN_W-1:OUT_W-1];
      assign u_ovf = |disc;
      assign s_ovf = !((&top) || !(|top));
      assign neg   = s1_data[IN_W-1];

      always_comb begin
        conv     = low;
        conv_ovf = 1'b0;
        case (s1_mode)
          2'b00: conv_ovf = u_ovf;
          2'b01: conv_ovf = s_ovf;
          2'b10: begin
            conv_ovf = s_ovf;
            if (s_ovf) conv = neg ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
          end
          default: begin
            conv_ovf = u_ovf;
            if (u_ovf) conv = '1;
          end
        endcase
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (bus.in_ready_o) s1_valid <= bus.in_valid_i;
      if (accept) begin
        s1_data <= bus.inval_i;
        s1_mode <= bus.mode_i;
      end
      if (s2_free) s2_valid <= s1_valid;
      if (advance) begin
        s2_data <= conv;
        s2_ovf  <= conv_ovf;
      end
      // If clear and increment happen together, clear takes priority.
      if (bus.clr_count_i) cnt_q <= '0;
      else if (deliver && s2_ovf && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_int_convert_pipe.sv
// tb_int_convert_pipe: self-checking bench for int_convert_pipe.
// It drives three instances with the same stimulus:
//   a: 8 -> 16 bits, 16-bit counter
//   b: 8 -> 4 bits,  16-bit counter
//   c: 8 -> 4 bits,  2-bit counter
// Expected values come from a reference model written as plain integer
// arithmetic (range check and clamp) plus an item queue.
module tb_int_convert_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] inval;
  logic [1:0] mode;
  logic       out_ready;
  logic       clr;

  int errors = 0;
  int checks = 0;

  int_convert_pipe_if #(.IN_W(8), .OUT_W(16), .CNT_W(16)) ifa ();
  int_convert_pipe_if #(.IN_W(8), .OUT_W(4),  .CNT_W(16)) ifb ();
  int_convert_pipe_if #(.IN_W(8), .OUT_W(4),  .CNT_W(2))  ifc ();

  assign ifa.in_valid_i  = in_valid;
  assign ifa.inval_i     = inval;
  assign ifa.mode_i      = mode;
  assign ifa.out_ready_i = out_ready;
  assign ifa.clr_count_i = clr;
  assign ifb.in_valid_i  = in_valid;
  assign ifb.inval_i     = inval;
  assign ifb.mode_i      = mode;
  assign ifb.out_ready_i = out_ready;
  assign ifb.clr_count_i = clr;
  assign ifc.in_valid_i  = in_valid;
  assign ifc.inval_i     = inval;
  assign ifc.mode_i      = mode;
  assign ifc.out_ready_i = out_ready;
  assign ifc.clr_count_i = clr;

  int_convert_pipe #(.IN_W(8), .OUT_W(16), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  int_convert_pipe #(.IN_W(8), .OUT_W(4), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb.slave));
  int_convert_pipe #(.IN_W(8), .OUT_W(4), .CNT_W(2)) dut_c (
    .clk_i(clk), .rst_i(rst), .bus(ifc.slave));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] v;
    logic [1:0] m;
    int         e;  // index of the edge that accepted the item
  } item_t;

  item_t exp_q[$];
  int    edge_now = 0;
  int    cnt_a = 0;
  int    cnt_b = 0;
  int    cnt_c = 0;

  // Returns {ovf, value masked to ow bits}.
  function automatic logic [16:0] conv_ref(logic [7:0] x, logic [1:0] m, int ow);
    longint v, lo, hi, r, mask;
    bit     sgn, ovf;
    sgn = (m == 2'b01) || (m == 2'b10);
    v   = longint'(x);
    if (sgn && v >= 128) v = v - 256;
    if (sgn) begin
      lo = -(longint'(1) << (ow - 1));
      hi = (longint'(1) << (ow - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << ow) - 1;
    end
    ovf = (v < lo) || (v > hi);
    if (m[1]) r = (v < lo) ? lo : (v > hi) ? hi : v;
    else      r = v;
    mask = (longint'(1) << ow) - 1;
    return {ovf, 16'(r & mask)};
  endfunction

  function automatic int sat_inc(int c, int maxv);
    return (c < maxv) ? c + 1 : c;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Outputs are compared at the falling edge. The model
  // then advances on the rising edge. Inputs must already be set.
  task automatic step(output bit acc);
    logic [16:0] ea, en;
    bit          vld, rdy, dlv, ovf4;
    item_t       h;
    @(negedge clk);
    rdy = (exp_q.size() < 2) || out_ready;
    vld = (exp_q.size() > 0) && (exp_q[0].e < edge_now);
    chk("a_in_ready",  32'(ifa.in_ready_o),  32'(rdy));
    chk("b_in_ready",  32'(ifb.in_ready_o),  32'(rdy));
    chk("c_in_ready",  32'(ifc.in_ready_o),  32'(rdy));
    chk("a_out_valid", 32'(ifa.out_valid_o), 32'(vld));
    chk("b_out_valid", 32'(ifb.out_valid_o), 32'(vld));
    chk("c_out_valid", 32'(ifc.out_valid_o), 32'(vld));
    if (vld) begin
      h  = exp_q[0];
      ea = conv_ref(h.v, h.m, 16);
      en = conv_ref(h.v, h.m, 4);
      chk("a_data", 32'(ifa.output__), 32'(ea[15:0]));
      chk("a_ovf",  32'(ifa.ovf_o),    32'(ea[16]));
      chk("b_data", 32'(ifb.output__), 32'(en[15:0]));
      chk("b_ovf",  32'(ifb.ovf_o),    32'(en[16]));
      chk("c_data", 32'(ifc.output__), 32'(en[15:0]));
      chk("c_ovf",  32'(ifc.ovf_o),    32'(en[16]));
    end
    chk("a_count", 32'(ifa.ovf_count_o), 32'(cnt_a));
    chk("b_count", 32'(ifb.ovf_count_o), 32'(cnt_b));
    chk("c_count", 32'(ifc.ovf_count_o), 32'(cnt_c));
    acc = in_valid && rdy;
    dlv = vld && out_ready;
    @(posedge clk);
    edge_now++;
    ovf4 = 1'b0;
    ea   = '0;
    if (dlv) begin
      h    = exp_q.pop_front();
      ea   = conv_ref(h.v, h.m, 16);
      ovf4 = conv_ref(h.v, h.m, 4) >> 16;
    end
    if (clr) begin
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
    end else begin
      if (dlv && ea[16]) cnt_a = sat_inc(cnt_a, 65535);
      if (dlv && ovf4) begin
        cnt_b = sat_inc(cnt_b, 65535);
        cnt_c = sat_inc(cnt_c, 3);
      end
    end
    if (acc) exp_q.push_back('{v: inval, m: mode, e: edge_now});
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(logic [7:0] v, logic [1:0] m);
    bit got;
    int n;
    in_valid = 1'b1;
    inval    = v;
    mode     = m;
    got      = 1'b0;
    n        = 0;
    while (!got && n < 20) begin
      step(got);
      n++;
    end
    chk("send_accepted", 32'(got), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit got;
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n         = 0;
    while (exp_q.size() > 0 && n < 20) begin
      step(got);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_a_in_ready",  32'(ifa.in_ready_o),  32'd1);
    chk("rst_a_out_valid", 32'(ifa.out_valid_o), 32'd0);
    chk("rst_a_data",      32'(ifa.output__),    32'd0);
    chk("rst_a_ovf",       32'(ifa.ovf_o),       32'd0);
    chk("rst_a_count",     32'(ifa.ovf_count_o), 32'd0);
    chk("rst_b_out_valid", 32'(ifb.out_valid_o), 32'd0);
    chk("rst_b_count",     32'(ifb.ovf_count_o), 32'd0);
    chk("rst_c_out_valid", 32'(ifc.out_valid_o), 32'd0);
    chk("rst_c_count",     32'(ifc.ovf_count_o), 32'd0);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    bit got;
    int idx;
    int cyc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    inval     = '0;
    mode      = '0;
    out_ready = 1'b1;
    clr       = 1'b0;

    // Values while reset is held
    #3;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Widening and sign handling, back to back at full throughput
    out_ready = 1'b1;
    send(8'h01, 2'b01);
    send(8'hFF, 2'b01);
    send(8'h8A, 2'b01);
    send(8'h8A, 2'b00);
    drain();

    // Narrowing cases, starting from a cleared counter
    clr = 1'b1;
    step(got);
    clr = 1'b0;
    send(8'h8A, 2'b00);
    send(8'h8A, 2'b01);
    send(8'h8A, 2'b10);
    send(8'h8A, 2'b11);
    send(8'hFF, 2'b01);
    send(8'h05, 2'b11);
    drain();
    chk("b_count_after_six", 32'(ifb.ovf_count_o), 32'd4);

    // Backpressure: 0x01..0x06 with out_ready low for three cycles
    idx = 0;
    cyc = 0;
    mode = 2'b00;
    while (idx < 6 && cyc < 40) begin
      in_valid  = 1'b1;
      inval     = 8'(idx + 1);
      out_ready = !(cyc >= 2 && cyc <= 4);
      step(got);
      if (got) idx++;
      cyc++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd6);
    drain();

    // Counter saturation on the 2-bit instance, then clear during a delivery
    clr = 1'b1;
    step(got);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h8A, 2'b00);
    drain();
    chk("c_count_sat", 32'(ifc.ovf_count_o), 32'd3);
    send(8'h8A, 2'b00);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clr = ifc.out_valid_o;
      step(got);
      if (clr) break;
    end
    clr = 1'b0;
    chk("c_count_clr_wins", 32'(ifc.ovf_count_o), 32'd0);
    chk("b_count_clr_wins", 32'(ifb.ovf_count_o), 32'd0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      inval     = 8'($urandom_range(0, 255));
      mode      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 31) == 0);
      step(got);
    end
    clr = 1'b0;
    drain();

    // Reset while both stages hold items
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      inval    = 8'hC3;
      mode     = 2'b10;
      step(got);
    end
    in_valid = 1'b0;
    chk("full_in_ready", 32'(ifa.in_ready_o), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    out_ready = 1'b1;
    send(8'h7E, 2'b11);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: stop with a FAIL line if the sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/int_convert_pipe.md
# int_convert_pipe

Registered, parametrised integer width converter with a valid/ready stream interface. It sign-extends, zero-extends, truncates or saturates an `IN_W`-bit value to `OUT_W` bits, selected per item by a 2-bit mode. It also flags each item whose value is not representable in the output and keeps a saturating overflow count. It sits on datapath boundaries where a producer and consumer disagree on integer width and backpressure must be honoured.

## Interface
- `IN_W`, 8, input data width (≥2)
- `OUT_W`, 16, output data width (≥2; may be <, = or > `IN_W`)
- `CNT_W`, 16, overflow counter width (≥1)

Ports:
- `clk_i`  in  1  clock, rising-edge
- `rst_i`  in  1  reset; asynchronous, active-high
- `in_valid_i`  in  1  input item present
- `in_ready_o`  out  1  block accepts input this cycle
- `inval_i`  in  `IN_W`  input value
- `mode_i`  in  2  per-item mode: 00 unsigned wrap, 01 signed wrap, 10 signed saturate, 11 unsigned saturate
- `out_valid_o`  out  1  output item present
- `out_ready_i`  in  1  consumer accepts output
- `output__`  out  `OUT_W`  converted value
- `ovf_o`  out  1  value of current output item not representable
- `ovf_count_o`  out  `CNT_W`  count of overflowed items delivered
- `clr_count_i`  in  1  synchronous clear of `ovf_count_o`

## Operation
- Two pipeline registers: S1 holds `{inval, mode}`; S2 holds `{output__, ovf}`. Conversion logic sits between S1 and S2.
- Transfer rules:
  - Input is accepted when `in_valid_i && in_ready_o`.
  - Output is delivered when `out_valid_o && out_ready_i`.
- Readiness:
  - `s2_free = !s2_valid || out_ready_i`.
  - `in_ready_o = !s1_valid || s2_free`. This is a combinational path from `out_ready_i`, and it is intentional.
- Values are interpreted as unsigned for modes 00/11 and as signed two's complement for modes 01/10.
- When `OUT_W >= IN_W`:
  - Modes 00/11 zero-extend.
  - Modes 01/10 sign-extend.
  - `ovf` is always 0.
- When `OUT_W < IN_W`:
  - 00: output is the low `OUT_W` bits. `ovf` = any discarded bit is 1.
  - 01: output is the low `OUT_W` bits. `ovf` = the top `IN_W-OUT_W+1` bits are not all equal.
  - 10: clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. `ovf` = clamping occurred.
  - 11: clamp to [0, 2^OUT_W−1]. `ovf` = clamping occurred.
- Overflow counter:
  - Increments by 1 on each delivered item with `ovf_o=1`.
  - Saturates at all-ones.
  - `clr_count_i` forces 0 next cycle; clear wins over a simultaneous increment.
- Data registers are loaded only on transfer; held values stay stable under backpressure.

## Timing
- Reset (async assert, released synchronously by the environment):
  - `s1_valid=0`, `s2_valid=0`, so `out_valid_o=0`.
  - `output__=0`, `ovf_o=0`, `ovf_count_o=0`.
  - `in_ready_o=1` immediately after reset asserts.
- Reset mid-stream: in-flight items are dropped and none is delivered after release.
- Latency: an item accepted on edge N is presented on `out_valid_o` after edge N+1. That is 2 edges from accept-cycle start to visible output.
- Throughput is 1 item/cycle with `out_ready_i` held high.
- Full: both stages valid and `out_ready_i=0` gives `in_ready_o=0`. Nothing changes and the output holds.
- Simultaneous accept and deliver with both stages full: S2←S1, S1←input, no bubble.
- Counter increments on the same edge that delivers the overflowing item.

## Test plan
- `IN_W=8`, `OUT_W=16`, `out_ready_i=1`:
  - `inval_i`=0x01 mode 01 → 0x0001, ovf 0.
  - 0xFF mode 01 → 0xFFFF, ovf 0.
  - 0x8A mode 01 → 0xFF8A.
  - 0x8A mode 00 → 0x008A.
  - Each output appears 2 edges after accept.
- `IN_W=8`, `OUT_W=4`, input 0x8A:
  - mode 00 → 0xA, ovf 1.
  - mode 01 → 0xA, ovf 1.
  - mode 10 → 0x8, ovf 1.
  - mode 11 → 0xF, ovf 1.
  - 0xFF mode 01 → 0xF, ovf 0.
  - 0x05 mode 11 → 0x5, ovf 0.
  - `ovf_count_o`=4 after these six items.
- Backpressure:
  - Stream 0x01..0x06 (mode 00, `OUT_W=16`) with `out_ready_i` low for 3 cycles mid-stream.
  - `in_ready_o` drops after two items buffer.
  - All six are delivered in order, with no duplicate or loss.
  - `output__` stays stable while stalled.
- Counter with `CNT_W=2`:
  - Deliver 5 overflowing items → count stops at 3.
  - Assert `clr_count_i` on the same cycle as a further overflowing delivery → count 0.
- Reset mid-operation:
  - Assert `rst_i` between clock edges while both stages are full.
  - `out_valid_o` goes 0 without waiting for a clock edge; count resets to 0.
  - After release, the first new item appears with normal 2-edge latency.
